opb_register_simulink2ppc_snap: RTL

OPB slave register for the reverse direction of the ppc2simulink control registers: fabric logic pushes a 32-bit word, and the PowerPC reads it over OPB. It holds the word with a new-data flag, a freeze control and a saturating overrun counter, so software can poll snapshot/vacc status words without tearing. It sits beside the ppc2simulink registers on the same OPB bus, one instance per readback word. The user side runs in the OPB clock domain.

---
 rtl/opb_register_simulink2ppc_snap.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB slave readback register: fabric pushes a 32-bit word, the PowerPC polls it over OPB.
// Latency: Sl_xferAck one cycle after the first hitting select cycle; capture takes one cycle.
// Backpressure: none on OPB; user_new mirrors the new-data flag so fabric can hold off.
module opb_register_simulink2ppc_snap #(
  parameter logic [31:0] C_BASEADDR   = 32'h01025000,
  parameter logic [31:0] C_HIGHADDR   = 32'h010250FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter logic [63:0] C_FAMILY     = "virtex6"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic                    Sl_xferAck,
  input  logic [31:0]             user_data_in,
  input  logic                    user_data_valid,
  output logic                    user_new
);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

  state_t      r_state;
  logic        r_ack;
  logic [31:0] r_dbus;
  logic        r_rnw;
  logic [1:0]  r_off;
  logic [31:0] r_data;
  logic        r_new;
  logic        r_freeze;
  logic [15:0] r_ovf;

  logic        w_hit;
  logic [1:0]  w_off;
  logic        w_start;
  logic        w_ctrl_wr;
  logic        w_wfreeze;
  logic        w_wclr;
  logic        w_cap;
  logic        w_data_rd_ack;
  logic [31:0] w_rd_val;
  logic        w_unused;

  // OPB is big-endian: bit 0 is the MSB, so ABus[28:29] are numeric address bits 3:2
  // and DBus[30:31] are register bits 1:0 (the byte lane covered by BE[3]).
  assign w_hit     = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign w_off     = OPB_ABus[28:29];
  assign w_start   = (r_state == S_IDLE) && w_hit;
  assign w_ctrl_wr = w_start && !OPB_RNW && (w_off == 2'd2) && OPB_BE[3];
  assign w_wfreeze = OPB_DBus[30];
  assign w_wclr    = OPB_DBus[31];

  // Freeze is the registered value, so a freeze written this cycle only blocks next cycle.
  assign w_cap         = user_data_valid && !r_freeze;
  assign w_data_rd_ack = (r_state == S_ACK) && r_rnw && (r_off == 2'd0);

  // Read mux, sampled into the output register at the IDLE->ACK edge
  always_comb begin
    w_rd_val = 32'h0;
    case (w_off)
      2'd0:    w_rd_val = r_data;
      2'd1:    w_rd_val = {r_ovf, 14'h0, r_freeze, r_new};
      2'd2:    w_rd_val = {30'h0, r_freeze, 1'b0};
      default: w_rd_val = 32'h0;
    endcase
  end

  // Bus FSM: one ack per select assertion, read data driven only during the ack cycle
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_dbus  <= 32'h0;
      r_rnw   <= 1'b0;
      r_off   <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_state <= S_ACK;
            r_ack   <= 1'b1;
            r_rnw   <= OPB_RNW;
            r_off   <= w_off;
            r_dbus  <= OPB_RNW ? w_rd_val : 32'h0;
          end
        end
        S_ACK: begin
          r_state <= S_WAIT;
          r_ack   <= 1'b0;
          r_dbus  <= 32'h0;
        end
        S_WAIT: begin
          if (!OPB_select) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_dbus  <= 32'h0;
        end
      endcase
    end
  end

  // Data capture, new flag, freeze control and saturating overrun counter
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      r_data   <= 32'h0;
      r_new    <= 1'b0;
      r_freeze <= 1'b0;
      r_ovf    <= 16'h0;
    end else begin
      // A capture landing on the DATA-read ack keeps new set: the fresh word is still unread.
      if (w_cap) begin
        r_data <= user_data_in;
        r_new  <= 1'b1;
      end else if (w_data_rd_ack) begin
        r_new  <= 1'b0;
      end
      if (w_ctrl_wr) r_freeze <= w_wfreeze;
      // Software clear beats a coincident overrun; an overrun needs an unread, unconsumed word.
      if (w_ctrl_wr && w_wclr) begin
        r_ovf <= 16'h0;
      end else if (w_cap && r_new && !w_data_rd_ack && (r_ovf != 16'hFFFF)) begin
        r_ovf <= r_ovf + 16'h1;
      end
    end
  end

  assign Sl_DBus    = r_dbus;
  assign Sl_xferAck = r_ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign user_new   = r_new;

  // Inputs that carry no function here (only CTRL bits 1:0 are writable)
  assign w_unused = ^{OPB_seqAddr, OPB_DBus[0:29], OPB_BE[0:2], C_FAMILY};

endmodule
